audio_frame_ctrl: RTL and testbench
===================================

Name: audio_frame_ctrl

Overview:
Sequences the codec playback path on the 96 MHz domain.
- Generates bclk and pblrc: 48 kHz frames, 250 bclk per frame.
- Fetches one parallel sample per frame from the tone generator over a req/valid handshake.
- Issues a one-cycle load strobe plus data to the parallel-to-serial shifter at each frame boundary.
- Applies freq changes only at frame boundaries; flags sample underruns.

Parameters:
BCLK_HALF, 4, clk96M cycles per bclk half-period (bclk = 12 MHz)
FRAME_BCLKS, 250, bclk periods per frame (frame = 2000 clk96M cycles)
REQ_BCLK, 200, bclk index within the frame at which sample_req is raised; must be < FRAME_BCLKS-1
SAMPLE_W, 16, width of the parallel sample

Ports:
clk96M  in  1  sole clock, 96 MHz
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  run enable; low holds the block idle
freq_in  in  15  requested tone frequency, Hz
freq_out  out  15  frequency presented to the tone generator, frame-aligned
sample_req  out  1  request for the next sample
sample_valid  in  1  upstream sample available
sample_data  in  SAMPLE_W  upstream sample
bclk  out  1  codec bit clock
pblrc  out  1  codec frame sync, high for the last bclk period of each frame
load  out  1  one-cycle strobe to the serializer
par_data  out  SAMPLE_W  sample for the serializer, valid while load=1 and held afterwards
underrun  out  1  sticky flag: a frame started without a fresh sample
underrun_clr  in  1  clears underrun

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, freq_out=0, counters 0, FSM IDLE, holding register 0.
- Timing counters:
  - hcnt counts 0..BCLK_HALF-1. bclk toggles on the cycle hcnt wraps.
  - bcnt counts 0..FRAME_BCLKS-1 and advances on each bclk 1->0 transition, wrapping to 0.
- pblrc = 1 iff bcnt == FRAME_BCLKS-1. It is registered and changes together with bclk falling.
- Frame boundary:
  - Defined as the cycle in which bcnt wraps to 0.
  - load=1 for exactly that one clk96M cycle, aligned with bclk falling and pblrc falling.
  - par_data takes the holding register value; freq_out takes freq_in.
- en=0: hcnt, bcnt, bclk, pblrc, load and sample_req are forced to 0 synchronously; FSM returns to IDLE. par_data, freq_out and underrun are held.
- After en rises, the first load occurs 2*BCLK_HALF*FRAME_BCLKS = 2000 cycles later.
- FSM states: IDLE, WAIT, REQ, READY.
  - IDLE -> WAIT when en=1.
  - WAIT -> REQ on the bcnt 199->200 transition (REQ_BCLK); sample_req=1 from that cycle.
  - REQ -> READY when sample_valid=1 while sample_req=1. The holding register captures sample_data; sample_req drops the next cycle.
  - REQ at the frame boundary (deadline): sample_req drops, underrun sets, the holding register keeps the previous sample (repeated to the serializer), -> WAIT.
  - READY -> WAIT at the frame boundary (normal load).
- Simultaneous events:
  - sample_valid in the boundary cycle itself is accepted: no underrun, and the new sample is loaded that same cycle (bypass into par_data).
  - underrun_clr in the same cycle as a new underrun: set wins.
  - sample_valid while sample_req=0 is ignored.
- Reset mid-frame aborts immediately. No load is issued until a full frame after reset release with en=1.

Decomposition:
- audio_pkg holds:
  - constants CLK_HZ=96_000_000, FS_HZ=48_000, the default BCLK_HALF/FRAME_BCLKS/REQ_BCLK;
  - the FSM enum type fctrl_state_t {IDLE, WAIT, REQ, READY};
  - the typedef sample_t = logic [15:0].
- One sub-module, audio_clkgen, owns hcnt/bcnt/bclk/pblrc and emits frame_tick and req_tick.
- audio_frame_ctrl instantiates audio_clkgen and contains the FSM, holding register, freq register and underrun flag.

Test Plan:
- Reset release, en=1, freq_in=440 -> bclk period 8 cycles; pblrc high 8 cycles every 2000; first load at cycle 2000 after en; freq_out=440 from that load.
- Upstream answers sample_req after 3 cycles with 0x1234 -> sample_req high exactly 4 cycles; next load has par_data=0x1234; underrun=0.
- No sample_valid during a frame -> load repeats the previous par_data; underrun=1 until underrun_clr; with clr and a new underrun in the same cycle, underrun stays 1.
- sample_valid asserted in the boundary cycle with 0xBEEF -> load in that cycle carries 0xBEEF; no underrun.
- freq_in changed 440->600 mid-frame -> freq_out stays 440 until the next load, then 600.
- en dropped mid-frame, and separately reset pulsed mid-frame -> bclk/pblrc/load/sample_req go to 0 (reset clears everything); restart yields first load 2000 cycles after en/reset release.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants, FSM state type and sample type for the
//               codec playback frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int CLK_HZ = 96_000_000;
  localparam int FS_HZ  = 48_000;

  // One audio frame in system clock cycles (2000 at 96 MHz / 48 kHz)
  localparam int DEF_FRAME_CYC   = CLK_HZ / FS_HZ;
  localparam int DEF_FRAME_BCLKS = 250;
  localparam int DEF_BCLK_HALF   = DEF_FRAME_CYC / (2 * DEF_FRAME_BCLKS);
  localparam int DEF_REQ_BCLK    = 200;
  localparam int DEF_SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    REQ   = 2'd2,
    READY = 2'd3
  } fctrl_state_t;

  typedef logic [15:0] sample_t;

  // Counter width for a modulo-n counter, never below one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_ctrl_if
// Description : Sample fetch handshake (tone generator side) and serializer
//               load path of the frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_frame_ctrl_if #(
  parameter int SAMPLE_W = 16
) ();

  logic                sample_req;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                load;
  logic [SAMPLE_W-1:0] par_data;

  // Frame controller side
  modport master (
    output sample_req, load, par_data,
    input  sample_valid, sample_data
  );

  // Tone generator / serializer side
  modport slave (
    input  sample_req, load, par_data,
    output sample_valid, sample_data
  );

endinterface
`default_nettype wire

// File: rtl/audio_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : audio_clkgen
// Description : Bit clock and frame sync generator. Emits one-cycle ticks
//               one cycle ahead of the bclk falling edge that starts a frame
//               (frame_tick) and that enters the request slot (req_tick).
// Revision    : 1.0 - initial release
// ============================================================================
module audio_clkgen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF   = DEF_BCLK_HALF,
  parameter int FRAME_BCLKS = DEF_FRAME_BCLKS,
  parameter int REQ_BCLK    = DEF_REQ_BCLK
) (
  input  logic clk96M,
  input  logic reset,
  input  logic en,
  output logic bclk,
  output logic pblrc,
  output logic frame_tick,
  output logic req_tick
);

  localparam int HW = cnt_w(BCLK_HALF);
  localparam int BW = cnt_w(FRAME_BCLKS);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bclk_q, bclk_d;
  logic          pblrc_q, pblrc_d;
  logic          h_wrap, b_fall;

  // Counter next-state; en low parks everything at zero
  always_comb begin
    h_wrap     = en && (hcnt_q == HW'(BCLK_HALF - 1));
    b_fall     = h_wrap && bclk_q;
    frame_tick = b_fall && (bcnt_q == BW'(FRAME_BCLKS - 1));
    req_tick   = b_fall && (bcnt_q == BW'(REQ_BCLK - 1));
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    bclk_d     = bclk_q;
    pblrc_d    = pblrc_q;
    if (!en) begin
      hcnt_d  = '0;
      bcnt_d  = '0;
      bclk_d  = 1'b0;
      pblrc_d = 1'b0;
    end else begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) bclk_d = ~bclk_q;
      if (b_fall) bcnt_d = frame_tick ? '0 : bcnt_q + 1'b1;
      // Follows bcnt, so it only ever moves with bclk falling
      pblrc_d = (bcnt_d == BW'(FRAME_BCLKS - 1));
    end
  end

  // Counter and clock output registers
  always_ff @(posedge clk96M or negedge reset) begin
    if (!reset) begin
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      bclk_q  <= 1'b0;
      pblrc_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      bclk_q  <= bclk_d;
      pblrc_q <= pblrc_d;
    end
  end

  assign bclk  = bclk_q;
  assign pblrc = pblrc_q;

endmodule
`default_nettype wire

// File: rtl/audio_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_ctrl
// Description : Codec playback frame sequencer: fetches one sample per frame,
//               strobes it into the serializer at the frame boundary, applies
//               frequency changes frame-aligned and flags underruns.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_ctrl
  import audio_pkg::*;
#(
  parameter int BCLK_HALF   = DEF_BCLK_HALF,
  parameter int FRAME_BCLKS = DEF_FRAME_BCLKS,
  parameter int REQ_BCLK    = DEF_REQ_BCLK,
  parameter int SAMPLE_W    = DEF_SAMPLE_W
) (
  input  logic                clk96M,
  input  logic                reset,
  input  logic                en,
  input  logic [14:0]         freq_in,
  output logic [14:0]         freq_out,
  output logic                bclk,
  output logic                pblrc,
  output logic                underrun,
  input  logic                underrun_clr,
  audio_frame_ctrl_if.master  bus
);

  fctrl_state_t        state_q, state_d;
  logic                sample_req_q, sample_req_d;
  logic                load_q, load_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] par_q, par_d;
  logic [14:0]         freq_q, freq_d;
  logic                frame_tick, req_tick, accept, underrun_set;

  audio_clkgen #(
    .BCLK_HALF   (BCLK_HALF),
    .FRAME_BCLKS (FRAME_BCLKS),
    .REQ_BCLK    (REQ_BCLK)
  ) u_clkgen (
    .clk96M     (clk96M),
    .reset      (reset),
    .en         (en),
    .bclk       (bclk),
    .pblrc      (pblrc),
    .frame_tick (frame_tick),
    .req_tick   (req_tick)
  );

  // Fetch FSM, holding register and frame-boundary load. frame_tick is the
  // last cycle of the frame; everything it decides becomes visible together
  // with bclk/pblrc falling, so a sample accepted in that cycle bypasses the
  // holding register straight into par_data.
  always_comb begin
    state_d      = state_q;
    sample_req_d = sample_req_q;
    load_d       = 1'b0;
    hold_d       = hold_q;
    par_d        = par_q;
    freq_d       = freq_q;
    underrun_set = 1'b0;
    accept       = sample_req_q && bus.sample_valid;
    if (!en) begin
      state_d      = IDLE;
      sample_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:  state_d = WAIT;
        WAIT: begin
          if (req_tick) begin
            state_d      = REQ;
            sample_req_d = 1'b1;
          end
        end
        REQ: begin
          if (accept) begin
            hold_d       = bus.sample_data;
            sample_req_d = 1'b0;
            state_d      = READY;
          end
          // Deadline: the previous sample is repeated if nothing arrived
          if (frame_tick) begin
            sample_req_d = 1'b0;
            state_d      = WAIT;
            underrun_set = !accept;
          end
        end
        READY: begin
          if (frame_tick) state_d = WAIT;
        end
        default: state_d = IDLE;
      endcase
      if (frame_tick) begin
        load_d = 1'b1;
        par_d  = accept ? bus.sample_data : hold_q;
        freq_d = freq_in;
      end
    end
    // A new underrun outranks a simultaneous clear
    if (underrun_set)      underrun_d = 1'b1;
    else if (underrun_clr) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  // Controller state registers
  always_ff @(posedge clk96M or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sample_req_q <= 1'b0;
      load_q       <= 1'b0;
      underrun_q   <= 1'b0;
      hold_q       <= '0;
      par_q        <= '0;
      freq_q       <= '0;
    end else begin
      state_q      <= state_d;
      sample_req_q <= sample_req_d;
      load_q       <= load_d;
      underrun_q   <= underrun_d;
      hold_q       <= hold_d;
      par_q        <= par_d;
      freq_q       <= freq_d;
    end
  end

  assign bus.sample_req = sample_req_q;
  assign bus.load       = load_q;
  assign bus.par_data   = par_q;
  assign freq_out       = freq_q;
  assign underrun       = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_frame_ctrl
// Description : Self-checking bench for audio_frame_ctrl: per-frame stimulus
//               table, load scoreboard, bclk/pblrc timing monitor and
//               hand-written en-drop / reset-pulse sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_frame_ctrl;

  localparam int FRAME   = 2000;
  localparam int REQ_OFS = 1600;
  localparam int PBL_OFS = 1992;

  localparam int M_RESP  = 0;  // answer the request after dly cycles
  localparam int M_NONE  = 1;  // never answer (underrun)
  localparam int M_BOUND = 2;  // answer in the last cycle of the frame
  localparam int C_NONE  = 0;
  localparam int C_EARLY = 1;  // clear pulse at frame start
  localparam int C_BOUND = 2;  // clear in the same cycle as a new underrun

  typedef struct {
    int          mode;
    int          dly;
    logic [15:0] data;
    logic [14:0] freq;
    int          clr;
    logic [15:0] exp_par;
    logic        exp_und;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] par;
    logic [14:0] freq;
  } exp_t;

  logic        clk96M = 1'b0;
  logic        reset, en, underrun_clr;
  logic [14:0] freq_in, freq_out;
  logic        bclk, pblrc, underrun;

  audio_frame_ctrl_if #(.SAMPLE_W(16)) bus ();

  audio_frame_ctrl #(
    .BCLK_HALF   (4),
    .FRAME_BCLKS (250),
    .REQ_BCLK    (200),
    .SAMPLE_W    (16)
  ) dut (
    .clk96M       (clk96M),
    .reset        (reset),
    .en           (en),
    .freq_in      (freq_in),
    .freq_out     (freq_out),
    .bclk         (bclk),
    .pblrc        (pblrc),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .bus          (bus)
  );

  always #5 clk96M = ~clk96M;

  int          cyc = 0;
  int          base = 0;
  int          tests = 0;
  int          fails = 0;
  logic [14:0] freq_m;
  logic [15:0] par_m;
  logic        und_m;
  exp_t        sb[$];
  exp_t        e;
  vec_t        vt[9];

  always @(posedge clk96M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Load scoreboard and bclk/pblrc timing monitor
  logic load_prev = 1'b0, bclk_prev = 1'b0, pblrc_prev = 1'b0;
  int   pblrc_rise = 0;
  always @(negedge clk96M) begin
    if (load_prev) check("load_width", {31'd0, bus.load}, 32'd0);
    if (bus.load) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_load at cycle %0d: got load=1, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("load_cycle", cyc, e.cyc);
        check("par_data", {16'd0, bus.par_data}, {16'd0, e.par});
        check("freq_out", {17'd0, freq_out}, {17'd0, e.freq});
        check("load_align", {28'd0, bclk_prev, bclk, pblrc_prev, pblrc}, 32'hA);
      end
    end
    if (en && reset) begin
      if (bclk && !bclk_prev) check("bclk_phase", (cyc - base) % 8, 32'd4);
      if (pblrc && !pblrc_prev) begin
        check("pblrc_rise", cyc - base, PBL_OFS);
        pblrc_rise = cyc;
      end
      if (!pblrc && pblrc_prev) check("pblrc_width", cyc - pblrc_rise, 32'd8);
    end
    load_prev  = bus.load;
    bclk_prev  = bclk;
    pblrc_prev = pblrc;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk96M);
  endtask

  // One full frame driven from a table entry
  task automatic run_frame(input vec_t v);
    int hi;
    if (v.clr == C_EARLY) begin
      @(negedge clk96M);
      underrun_clr = 1'b1;
      @(negedge clk96M);
      underrun_clr = 1'b0;
      check("underrun_clr", {31'd0, underrun}, 32'd0);
    end
    if (v.mode == M_NONE) begin
      // valid without a request must be ignored
      wait_cyc(base + 100);
      bus.sample_valid = 1'b1;
      bus.sample_data  = 16'hBAD0;
      @(negedge clk96M);
      bus.sample_valid = 1'b0;
      bus.sample_data  = 16'h0000;
    end
    for (int k = 0; k < FRAME + 100; k++) begin
      @(negedge clk96M);
      if (bus.sample_req) break;
    end
    if (!bus.sample_req) begin
      check("req_timeout", {31'd0, bus.sample_req}, 32'd1);
      return;
    end
    check("req_rise", cyc, base + REQ_OFS);
    freq_in = v.freq;
    check("freq_hold", {17'd0, freq_out}, {17'd0, freq_m});
    case (v.mode)
      M_RESP: begin
        hi = 1;
        repeat (v.dly) begin
          @(negedge clk96M);
          if (bus.sample_req) hi++;
        end
        bus.sample_valid = 1'b1;
        bus.sample_data  = v.data;
        sb.push_back('{base + FRAME, v.exp_par, v.freq});
        @(negedge clk96M);
        bus.sample_valid = 1'b0;
        bus.sample_data  = 16'hDEAD;
        check("req_width", hi, v.dly + 1);
        check("req_drop", {31'd0, bus.sample_req}, 32'd0);
      end
      M_BOUND: begin
        wait_cyc(base + FRAME - 1);
        check("req_at_bound", {31'd0, bus.sample_req}, 32'd1);
        bus.sample_valid = 1'b1;
        bus.sample_data  = v.data;
        sb.push_back('{base + FRAME, v.exp_par, v.freq});
        @(negedge clk96M);
        bus.sample_valid = 1'b0;
        bus.sample_data  = 16'hDEAD;
      end
      default: begin
        sb.push_back('{base + FRAME, v.exp_par, v.freq});
        if (v.clr == C_BOUND) begin
          wait_cyc(base + FRAME - 1);
          underrun_clr = 1'b1;
          @(negedge clk96M);
          underrun_clr = 1'b0;
        end
      end
    endcase
    wait_cyc(base + FRAME);
    check("underrun", {31'd0, underrun}, {31'd0, v.exp_und});
    check("req_after_load", {31'd0, bus.sample_req}, 32'd0);
    freq_m = v.freq;
    par_m  = v.exp_par;
    und_m  = v.exp_und;
    base   = base + FRAME;
  endtask

  // en dropped while a request is outstanding
  task automatic en_drop_seq();
    wait_cyc(base + 1700);
    check("req_before_drop", {31'd0, bus.sample_req}, 32'd1);
    en = 1'b0;
    @(negedge clk96M);
    check("en_drop_zero", {28'd0, bclk, pblrc, bus.load, bus.sample_req}, 32'd0);
    check("en_drop_par", {16'd0, bus.par_data}, {16'd0, par_m});
    check("en_drop_freq", {17'd0, freq_out}, {17'd0, freq_m});
    check("en_drop_und", {31'd0, underrun}, {31'd0, und_m});
    repeat (5) @(negedge clk96M);
    en   = 1'b1;
    base = cyc;
  endtask

  // Asynchronous reset pulse in the middle of a frame
  task automatic reset_seq();
    wait_cyc(base + 1000);
    reset = 1'b0;
    #1;
    check("rst_mid_zero", {27'd0, bclk, pblrc, bus.load, bus.sample_req, underrun}, 32'd0);
    check("rst_mid_par", {16'd0, bus.par_data}, 32'd0);
    check("rst_mid_freq", {17'd0, freq_out}, 32'd0);
    @(negedge clk96M);
    @(negedge clk96M);
    reset  = 1'b1;
    base   = cyc;
    freq_m = '0;
    par_m  = '0;
    und_m  = 1'b0;
  endtask

  initial begin
    vt[0] = '{M_RESP,  3, 16'h1234, 15'd440,   C_NONE,  16'h1234, 1'b0};
    vt[1] = '{M_NONE,  0, 16'h0000, 15'd440,   C_NONE,  16'h1234, 1'b1};
    vt[2] = '{M_NONE,  0, 16'h0000, 15'd440,   C_BOUND, 16'h1234, 1'b1};
    vt[3] = '{M_RESP,  0, 16'h5A5A, 15'd600,   C_EARLY, 16'h5A5A, 1'b0};
    vt[4] = '{M_BOUND, 0, 16'hBEEF, 15'd600,   C_NONE,  16'hBEEF, 1'b0};
    vt[5] = '{M_RESP,  7, 16'h8001, 15'd1000,  C_NONE,  16'h8001, 1'b0};
    vt[6] = '{M_RESP,  2, 16'h0F0F, 15'd2000,  C_NONE,  16'h0F0F, 1'b0};
    vt[7] = '{M_NONE,  0, 16'h0000, 15'd123,   C_NONE,  16'h0000, 1'b1};
    vt[8] = '{M_RESP,  1, 16'h7FFF, 15'd32767, C_NONE,  16'h7FFF, 1'b1};

    reset            = 1'b0;
    en               = 1'b0;
    underrun_clr     = 1'b0;
    freq_in          = 15'd440;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 16'h0000;
    repeat (3) @(negedge clk96M);
    check("rst_bclk",  {31'd0, bclk}, 32'd0);
    check("rst_pblrc", {31'd0, pblrc}, 32'd0);
    check("rst_load",  {31'd0, bus.load}, 32'd0);
    check("rst_req",   {31'd0, bus.sample_req}, 32'd0);
    check("rst_und",   {31'd0, underrun}, 32'd0);
    check("rst_par",   {16'd0, bus.par_data}, 32'd0);
    check("rst_freq",  {17'd0, freq_out}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk96M);
    check("idle_no_en", {29'd0, bclk, pblrc, bus.sample_req}, 32'd0);

    en     = 1'b1;
    base   = cyc;
    freq_m = '0;
    par_m  = '0;
    und_m  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) en_drop_seq();
      if (i == 7) reset_seq();
      run_frame(vt[i]);
    end
    repeat (10) @(negedge clk96M);
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0d cycles", 100_000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
